// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory with a fixed LAT-cycle access.
// Define MEM_ARB_RR_EN to grant ties round-robin; otherwise ties always go to load/store.
module mem_arb #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic        grant_ls, grant_ls_n;
    logic        we, we_n;
    logic [31:0] addr_n, wdata_n, if_rdata_n, ls_rdata_n;
    logic        read_n, write_n, if_ack_n, ls_ack_n, busy_n;
    logic        pick_ls;

`ifdef MEM_ARB_RR_EN
    logic last_ls, last_ls_n;
    // On a tie, ls wins only if fetch was granted most recently.
    assign pick_ls = ls_req && (!if_req || !last_ls);
`else
    assign pick_ls = ls_req;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        grant_ls_n = grant_ls;
        we_n       = we;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        if_rdata_n = if_rdata;
        ls_rdata_n = ls_rdata;
        read_n     = 1'b0;
        write_n    = 1'b0;
        if_ack_n   = 1'b0;
        ls_ack_n   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_ls_n  = last_ls;
`endif
        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    grant_ls_n = pick_ls;
                    we_n       = pick_ls && ls_we;
                    addr_n     = pick_ls ? ls_addr : if_addr;
                    wdata_n    = ls_wdata;
                    cnt_n      = 3'(LAT - 1);
                    read_n     = !we_n;
                    write_n    = we_n;
                    state_n    = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_ls_n  = pick_ls;
`endif
                end
            end
            ACCESS: begin
                if (cnt == 3'd0) begin
                    if (!we) begin
                        if (grant_ls) ls_rdata_n = mem_rdata;
                        else          if_rdata_n = mem_rdata;
                    end
                    if_ack_n = !grant_ls;
                    ls_ack_n = grant_ls;
                    state_n  = DONE;
                end else begin
                    cnt_n   = cnt - 3'd1;
                    read_n  = !we;
                    write_n = we;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_ls  <= 1'b0;
            we        <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_ls   <= 1'b1;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            grant_ls  <= grant_ls_n;
            we        <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            if_rdata  <= if_rdata_n;
            ls_rdata  <= ls_rdata_n;
            mem_read  <= read_n;
            mem_write <= write_n;
            if_ack    <= if_ack_n;
            ls_ack    <= ls_ack_n;
            busy      <= busy_n;
`ifdef MEM_ARB_RR_EN
            last_ls   <= last_ls_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: three instances (LAT 2, 1, 7) share the requester inputs
// and are compared every cycle against a transaction-timeline reference model.
module tb_mem_arb;

    localparam int NI = 3;
    localparam int unsigned LV [NI] = '{2, 1, 7};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic        if_ack [NI], ls_ack [NI], mem_read [NI], mem_write [NI], busy [NI];
    logic [31:0] if_rdata [NI], ls_rdata [NI], mem_addr [NI], mem_wdata [NI], mem_rdata [NI];

    int unsigned cyc = 0;
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_val = '0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    // Memory contents depend on address and on the cycle, so capturing in the wrong cycle shows.
    function automatic logic [31:0] memval(input logic [31:0] a, input int unsigned c,
                                           input logic fe, input logic [31:0] fv);
        return fe ? fv : ((a * 32'h9E37_79B1) ^ (c * 32'h0100_0193) ^ 32'h5A5A_0000);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_arb #(.LAT(LV[g])) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
            .ls_ack(ls_ack[g]), .ls_rdata(ls_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
        assign mem_rdata[g] = mem_read[g] ? memval(mem_addr[g], cyc, fixed_en, fixed_val)
                                          : 32'hBAD0_BAD0;
    end

    // Reference model: one granted transaction per instance, described by its decision cycle.
    int unsigned t_n [NI], t_free [NI];
    bit          t_valid [NI], t_ls [NI], t_we [NI], last_ls [NI];
    logic [31:0] t_addr [NI], t_wdata [NI], t_val [NI], e_if_rd [NI], e_ls_rd [NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            t_valid[k] = 1'b0;
            e_if_rd[k] = '0;
            e_ls_rd[k] = '0;
            last_ls[k] = 1'b1;
        end
    endtask

    task automatic decide();
        for (int k = 0; k < NI; k++) begin
            if (!rst && cyc >= t_free[k] && (if_req || ls_req)) begin
                bit pl;
`ifdef MEM_ARB_RR_EN
                pl = ls_req && (!if_req || !last_ls[k]);
`else
                pl = ls_req;
`endif
                last_ls[k] = pl;
                t_valid[k] = 1'b1;
                t_n[k]     = cyc;
                t_ls[k]    = pl;
                t_we[k]    = pl && ls_we;
                t_addr[k]  = pl ? ls_addr : if_addr;
                t_wdata[k] = ls_wdata;
                t_val[k]   = memval(t_addr[k], cyc + LV[k], fixed_en, fixed_val);
                t_free[k]  = cyc + LV[k] + 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            bit st, ak;
            string p;
            p  = $sformatf("L%0d", LV[k]);
            st = t_valid[k] && cyc > t_n[k] && cyc <= t_n[k] + LV[k];
            ak = t_valid[k] && cyc == t_n[k] + LV[k] + 1;
            if (ak && !t_we[k]) begin
                if (t_ls[k]) e_ls_rd[k] = t_val[k];
                else         e_if_rd[k] = t_val[k];
            end
            check({p, "_mem_read"},  32'(mem_read[k]),  32'(st && !t_we[k]));
            check({p, "_mem_write"}, 32'(mem_write[k]), 32'(st && t_we[k]));
            check({p, "_if_ack"},    32'(if_ack[k]),    32'(ak && !t_ls[k]));
            check({p, "_ls_ack"},    32'(ls_ack[k]),    32'(ak && t_ls[k]));
            check({p, "_busy"},      32'(busy[k]),      32'(st || ak));
            check({p, "_if_rdata"},  if_rdata[k], e_if_rd[k]);
            check({p, "_ls_rdata"},  ls_rdata[k], e_ls_rd[k]);
            if (st) check({p, "_mem_addr"}, mem_addr[k], t_addr[k]);
            if (st && t_we[k]) check({p, "_mem_wdata"}, mem_wdata[k], t_wdata[k]);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                         input logic [31:0] la, input logic [31:0] ld);
        if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
        decide();
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            string p;
            p = $sformatf("%s_L%0d", tag, LV[k]);
            check({p, "_mem_read"},  32'(mem_read[k]),  '0);
            check({p, "_mem_write"}, 32'(mem_write[k]), '0);
            check({p, "_if_ack"},    32'(if_ack[k]),    '0);
            check({p, "_ls_ack"},    32'(ls_ack[k]),    '0);
            check({p, "_busy"},      32'(busy[k]),      '0);
            check({p, "_mem_addr"},  mem_addr[k],  '0);
            check({p, "_mem_wdata"}, mem_wdata[k], '0);
            check({p, "_if_rdata"},  if_rdata[k],  '0);
            check({p, "_ls_rdata"},  ls_rdata[k],  '0);
        end
    endtask

    // Asynchronous reset mid-cycle, held over one edge, released mid-cycle.
    task automatic reset_now();
        #2 rst = 1'b1;
        #1 chk_zero("rst");
        model_reset();
        idle(1);
        #2 rst = 1'b0;
        for (int k = 0; k < NI; k++) t_free[k] = cyc;
    endtask

    initial begin
        logic [3:0] seq, seq_exp;
        int         n;

        model_reset();
        for (int k = 0; k < NI; k++) t_free[k] = 0;
        idle(2);
        chk_zero("por");
        #2 rst = 1'b0;
        for (int k = 0; k < NI; k++) t_free[k] = cyc;

        // Single fetch returning 0x13, first request straight after reset release.
        fixed_en = 1'b1; fixed_val = 32'h0000_0013;
        drive(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
        idle(10);
        for (int k = 0; k < NI; k++) check($sformatf("fetch13_L%0d", LV[k]), if_rdata[k], 32'h13);
        fixed_en = 1'b0;

        // Store must not disturb ls_rdata.
        drive(1'b0, '0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        idle(10);
        drive(1'b0, '0, 1'b1, 1'b0, 32'h30, '0);
        idle(10);
        drive(1'b0, '0, 1'b1, 1'b1, 32'h24, 32'h1234_5678);
        idle(10);

        // Reset in the second strobe cycle of a load.
        drive(1'b0, '0, 1'b1, 1'b0, 32'h40, '0);
        idle(1);
        reset_now();
        idle(2);

        // Both requesters held high: grant order.
        reset_now();
        seq = '0; n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            drive(1'b1, $urandom, 1'b1, 1'b0, $urandom, $urandom);
            if (if_ack[0] || ls_ack[0]) begin
                seq[n] = ls_ack[0];
                n++;
            end
        end
`ifdef MEM_ARB_RR_EN
        seq_exp = 4'b1010;
`else
        seq_exp = 4'b1111;
`endif
        check("tie_grants", 32'(n), 32'd4);
        check("tie_order", 32'(seq), 32'(seq_exp));
        idle(10);

        // Random traffic with inputs wandering after grant and occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 99) < 45),
                  1'($urandom), $urandom, $urandom);
            if (i % 150 == 149) reset_now();
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
